// File: rtl/mult5_seq_ctrl.sv
// Sequencing controller for the iterative shift-and-add multiplier:
// start/ack handshake, one partial product per RUN cycle, held result with io output-enable.
module mult5_seq_ctrl #(
    parameter int unsigned W          = 5,
    parameter int unsigned EARLY_EXIT = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic [W-1:0]     op_a_i,
    input  logic [W-1:0]     op_b_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*W-1:0]   product_o,
    output logic [2*W-1:0]   res_oeb_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam int unsigned PW     = 2 * W;
    localparam int unsigned STEP_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [PW-1:0]       acc_q, acc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PW-1:0]       product_q, product_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PW-1:0]       oeb_q, oeb_d;

    logic [PW-1:0]       sum;
    logic                last_step;

    // Partial-product add and RUN exit condition.
    always_comb begin
        sum       = acc_q + (b_q[0] ? a_q : '0);
        last_step = (step_q == STEP_W'(W - 1))
                 || ((EARLY_EXIT != 0) && ((b_q >> 1) == '0));
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            step_q    <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            oeb_q     <= '1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            step_q    <= step_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            oeb_q     <= oeb_d;
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        step_d    = step_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = PW'(op_a_i);
                    b_d     = op_b_i;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d  = sum;
                a_d    = a_q << 1;
                b_d    = b_q >> 1;
                step_d = step_q + STEP_W'(1);
                if (last_step) begin
                    product_d = sum;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs registered alongside the state they describe.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        oeb_d  = (state_d == ST_DONE) ? '0 : '1;
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign product_o  = product_q;
    assign res_oeb_o  = oeb_q;
    assign op_count_o = cnt_q;

endmodule

// File: tb/tb_mult5_seq_ctrl.sv
// Randomized self-checking bench: one early-exit instance and one full-latency instance,
// both checked against a plain arithmetic model of product, RUN length and op count.
module tb_mult5_seq_ctrl;

    localparam int unsigned W  = 5;
    localparam int unsigned PW = 2 * W;

    logic clk;
    logic rst_n;

    logic          start1, ack1, start0, ack0;
    logic [W-1:0]  a1, b1, a0, b0;
    logic          busy1, done1, busy0, done0;
    logic [PW-1:0] prod1, oeb1, prod0, oeb0;
    logic [7:0]    cnt1, cnt0;

    logic [7:0]    cnt_exp [2];
    int            checks;
    int            errors;

    mult5_seq_ctrl #(.W(W), .EARLY_EXIT(1), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start1), .op_a_i(a1), .op_b_i(b1),
        .ack_i(ack1), .busy_o(busy1), .done_o(done1), .product_o(prod1),
        .res_oeb_o(oeb1), .op_count_o(cnt1)
    );

    mult5_seq_ctrl #(.W(W), .EARLY_EXIT(0), .CNT_W(8)) dut_full (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start0), .op_a_i(a0), .op_b_i(b0),
        .ack_i(ack0), .busy_o(busy0), .done_o(done0), .product_o(prod0),
        .res_oeb_o(oeb0), .op_count_o(cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // RUN length from the spec: full W cycles, or highest set multiplier bit + 1 with early exit.
    function automatic int exp_cycles(input int ee, input logic [W-1:0] b);
        int m;
        if (ee == 0) return W;
        m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i;
        return m + 1;
    endfunction

    task automatic drive(input int w, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic k);
        if (w == 1) begin start1 = s; a1 = a; b1 = b; ack1 = k; end
        else        begin start0 = s; a0 = a; b0 = b; ack0 = k; end
    endtask

    function automatic logic [31:0] obs_busy(input int w); return w == 1 ? 32'(busy1) : 32'(busy0); endfunction
    function automatic logic [31:0] obs_done(input int w); return w == 1 ? 32'(done1) : 32'(done0); endfunction
    function automatic logic [31:0] obs_prod(input int w); return w == 1 ? 32'(prod1) : 32'(prod0); endfunction
    function automatic logic [31:0] obs_oeb(input int w);  return w == 1 ? 32'(oeb1)  : 32'(oeb0);  endfunction
    function automatic logic [31:0] obs_cnt(input int w);  return w == 1 ? 32'(cnt1)  : 32'(cnt0);  endfunction

    // One full operation on instance w; optionally hold start through RUN/DONE and scramble operands mid-RUN.
    task automatic run_op(input int w, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold_start, input bit chg_ops);
        int cyc;
        int guard;
        logic [31:0] exp_prod;
        exp_prod = 32'(a) * 32'(b);
        @(negedge clk);
        drive(w, 1'b1, a, b, 1'b0);
        @(posedge clk);
        #1;
        drive(w, hold_start, chg_ops ? ~a : a, chg_ops ? ~b : b, 1'b0);
        cyc   = 0;
        guard = 0;
        @(negedge clk);
        while (obs_busy(w) == 1 && guard < 40) begin
            cyc++;
            guard++;
            @(negedge clk);
        end
        cnt_exp[w] = cnt_exp[w] + 8'd1;
        check_eq("run_cycles", 32'(cyc), 32'(exp_cycles(w, b)));
        check_eq("done_high", obs_done(w), 32'd1);
        check_eq("product", obs_prod(w), exp_prod);
        check_eq("oeb_drive", obs_oeb(w), 32'd0);
        check_eq("op_count", obs_cnt(w), 32'(cnt_exp[w]));
        if (hold_start) begin
            repeat (3) @(negedge clk);
            check_eq("done_held", obs_done(w), 32'd1);
            check_eq("count_held", obs_cnt(w), 32'(cnt_exp[w]));
            check_eq("product_held", obs_prod(w), exp_prod);
        end
        drive(w, hold_start, chg_ops ? ~a : a, chg_ops ? ~b : b, 1'b1);
        @(posedge clk);
        #1;
        drive(w, 1'b0, a, b, 1'b0);
        @(negedge clk);
        check_eq("done_low", obs_done(w), 32'd0);
        check_eq("oeb_release", obs_oeb(w), 32'h3FF);
        check_eq("idle_not_busy", obs_busy(w), 32'd0);
        check_eq("product_kept", obs_prod(w), exp_prod);
        check_eq("count_after", obs_cnt(w), 32'(cnt_exp[w]));
    endtask

    task automatic check_reset_vals(input int w, input string tag);
        check_eq({tag, "_busy"}, obs_busy(w), 32'd0);
        check_eq({tag, "_done"}, obs_done(w), 32'd0);
        check_eq({tag, "_prod"}, obs_prod(w), 32'd0);
        check_eq({tag, "_oeb"},  obs_oeb(w),  32'h3FF);
        check_eq({tag, "_cnt"},  obs_cnt(w),  32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cnt_exp[0] = '0;
        cnt_exp[1] = '0;
        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_vals(0, "rst0");
        check_reset_vals(1, "rst1");
        rst_n = 1'b1;

        // Full-latency instance: worst case, then random operands.
        run_op(0, 5'd31, 5'd31, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(0, W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), 1'b0, 1'b0);

        // Early-exit instance: directed cases.
        run_op(1, 5'd5, 5'd7, 1'b0, 1'b0);
        run_op(1, 5'd9, 5'd0, 1'b0, 1'b0);
        run_op(1, 5'd31, 5'd31, 1'b0, 1'b0);
        run_op(1, 5'd13, 5'd22, 1'b1, 1'b1);
        run_op(1, 5'd31, 5'd16, 1'b1, 1'b0);
        run_op(0, 5'd6, 5'd11, 1'b1, 1'b1);

        // Randomized mix across both instances and handshake variants.
        for (int i = 0; i < 30; i++)
            run_op(int'($urandom_range(0, 1)), W'($urandom_range(0, 31)), W'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset during RUN step 2 aborts without counting.
        @(negedge clk);
        drive(1, 1'b1, 5'd9, 5'd31, 1'b0);
        drive(0, 1'b1, 5'd9, 5'd31, 1'b0);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 5'd9, 5'd31, 1'b0);
        drive(0, 1'b0, 5'd9, 5'd31, 1'b0);
        @(posedge clk);
        #1;
        check_eq("pre_abort_busy", obs_busy(1), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals(1, "abort1");
        check_reset_vals(0, "abort0");
        @(negedge clk);
        rst_n = 1'b1;
        cnt_exp[0] = '0;
        cnt_exp[1] = '0;
        run_op(1, 5'd3, 5'd4, 1'b0, 1'b0);
        run_op(0, 5'd3, 5'd4, 1'b0, 1'b0);

        // Counter wrap on the early-exit instance.
        for (int i = 0; i < 256; i++) begin
            run_op(1, 5'd1, 5'd1, 1'b0, 1'b0);
            if (cnt_exp[1] == 8'd0) check_eq("count_wrap", obs_cnt(1), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck handshake still reaches the summary.
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
